// File: rtl/rgb_pwm_pkg.sv
// Shared types and constants for the RGB PWM crossfader.
// Channel indices map directly onto the bits of the sequencer colour code.
package rgb_pwm_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      FADING = 1'b1
   } fade_state_t;

   localparam int NUM_CH = 3;
   localparam int CH_R   = 2;
   localparam int CH_G   = 1;
   localparam int CH_B   = 0;

   localparam int DEF_PWM_BITS  = 8;
   localparam int DEF_PRESCALE  = 4;
   localparam int DEF_FADE_STEP = 16;

endpackage

// File: rtl/pwm_fade_channel.sv
// One colour channel: a level register that walks toward its target in
// saturating steps once per PWM period, plus the registered PWM comparator.
module pwm_fade_channel
   import rgb_pwm_pkg::*;
#(
   parameter int PWM_BITS  = DEF_PWM_BITS,
   parameter int FADE_STEP = DEF_FADE_STEP
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_wrap,
   input  logic                i_enable,
   input  logic [PWM_BITS-1:0] i_tgt,
   input  logic [PWM_BITS-1:0] i_cnt,
   output logic [PWM_BITS-1:0] o_level,
   output logic                o_led
);

   localparam logic [PWM_BITS:0] STEP = (PWM_BITS+1)'(FADE_STEP);

   logic [PWM_BITS-1:0] r_level;
   logic                r_led;
   logic [PWM_BITS-1:0] w_next;
   logic [PWM_BITS:0]   w_lvl_ext;
   logic [PWM_BITS:0]   w_tgt_ext;
   logic [PWM_BITS:0]   w_up;
   logic [PWM_BITS:0]   w_lo_lim;

   // One extra bit keeps both the up-step and the down-step limit free of wrap-around.
   assign w_lvl_ext = {1'b0, r_level};
   assign w_tgt_ext = {1'b0, i_tgt};
   assign w_up      = w_lvl_ext + STEP;
   assign w_lo_lim  = w_tgt_ext + STEP;

   // Saturating step toward target; level-STEP < tgt is tested as level < tgt+STEP.
   always_comb begin
      w_next = r_level;
      if (r_level < i_tgt) begin
         if (w_up > w_tgt_ext) w_next = i_tgt;
         else                  w_next = w_up[PWM_BITS-1:0];
      end else if (r_level > i_tgt) begin
         if (w_lvl_ext < w_lo_lim) w_next = i_tgt;
         else                      w_next = r_level - STEP[PWM_BITS-1:0];
      end else begin
         w_next = r_level;
      end
   end

   // Level register updated at the period boundary; PWM pin registered every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_level <= {PWM_BITS{1'b0}};
         r_led   <= 1'b0;
      end else begin
         if (i_wrap) r_level <= w_next;
         r_led <= i_enable && (i_cnt < r_level);
      end
   end

   assign o_level = r_level;
   assign o_led   = r_led;

endmodule

// File: rtl/rgb_pwm_fader.sv
// RGB LED driver: per-channel PWM with linear crossfades between colour codes,
// global brightness and an output enable that leaves the fade engine running.
module rgb_pwm_fader
   import rgb_pwm_pkg::*;
#(
   parameter int PWM_BITS  = DEF_PWM_BITS,
   parameter int PRESCALE  = DEF_PRESCALE,
   parameter int FADE_STEP = DEF_FADE_STEP
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [2:0]          colour,
   input  logic [PWM_BITS-1:0] brightness,
   input  logic                enable,
   output logic                led_r,
   output logic                led_g,
   output logic                led_b,
   output logic                busy
);

   localparam int               PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

   logic [PSC_W-1:0]    r_presc;
   logic [PWM_BITS-1:0] r_cnt;
   fade_state_t         r_state;
   fade_state_t         w_state_next;
   logic                w_tick;
   logic                w_wrap;
   logic                w_mismatch;
   logic [NUM_CH-1:0]   w_diff;
   logic [NUM_CH-1:0]   w_led;
   logic [PWM_BITS-1:0] w_tgt   [NUM_CH];
   logic [PWM_BITS-1:0] w_level [NUM_CH];

   assign w_tick = (r_presc == PSC_LAST);
   assign w_wrap = w_tick && (r_cnt == {PWM_BITS{1'b1}});

   // Prescaler divides clk down to the PWM tick rate.
   always_ff @(posedge clk) begin
      if (rst)         r_presc <= {PSC_W{1'b0}};
      else if (w_tick) r_presc <= {PSC_W{1'b0}};
      else             r_presc <= r_presc + PSC_W'(1);
   end

   // PWM phase counter, free-running modulo 2^PWM_BITS.
   always_ff @(posedge clk) begin
      if (rst)         r_cnt <= {PWM_BITS{1'b0}};
      else if (w_tick) r_cnt <= r_cnt + PWM_BITS'(1);
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign w_tgt[i]  = colour[i] ? brightness : {PWM_BITS{1'b0}};
      assign w_diff[i] = (w_level[i] != w_tgt[i]);

      pwm_fade_channel #(
         .PWM_BITS  (PWM_BITS),
         .FADE_STEP (FADE_STEP)
      ) u_chan (
         .clk      (clk),
         .rst      (rst),
         .i_wrap   (w_wrap),
         .i_enable (enable),
         .i_tgt    (w_tgt[i]),
         .i_cnt    (r_cnt),
         .o_level  (w_level[i]),
         .o_led    (w_led[i])
      );
   end

   assign w_mismatch = |w_diff;

   // Fade state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   // Busy whenever any channel has not yet reached its target.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_mismatch) w_state_next = FADING;
            else            w_state_next = IDLE;
         end
         FADING: begin
            if (w_mismatch) w_state_next = FADING;
            else            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign busy  = (r_state == FADING);
   assign led_r = w_led[CH_R];
   assign led_g = w_led[CH_G];
   assign led_b = w_led[CH_B];

endmodule

// File: doc/rgb_pwm_fader.md
Name: rgb_pwm_fader

Overview:
- Downstream stage of the button-driven colour sequencer.
- Consumes its 3-bit colour code and drives the three physical LED pins (R, G, B) with PWM.
- Each channel crossfades linearly to its new level instead of switching abruptly.
- Brightness is global and runtime-adjustable; enable gates the pins without disturbing internal state.

Parameters:
- PWM_BITS, 8, width of PWM counter, channel levels and brightness; period = 2^PWM_BITS ticks.
- PRESCALE, 4, clk cycles per PWM tick (>=1); period = PRESCALE*2^PWM_BITS clk cycles.
- FADE_STEP, 16, level change per channel per PWM period during a fade (1..2^PWM_BITS-1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- colour  in  3  colour code from sequencer; bit2=R, bit1=G, bit0=B
- brightness  in  PWM_BITS  target level for any channel whose colour bit is 1
- enable  in  1  1: pins follow PWM; 0: pins forced low
- led_r  out  1  red PWM pin, registered
- led_g  out  1  green PWM pin, registered
- led_b  out  1  blue PWM pin, registered
- busy  out  1  high while any channel level differs from its target

Behaviour:
- Clock and reset: clk, rst synchronous active-high.
- Reset: prescaler=0, cnt=0, all levels=0, state=IDLE, led_r/g/b=0, busy=0. Reset mid-fade aborts the fade immediately; there is no resume.

Timing:
- Prescaler counts 0..PRESCALE-1; tick asserts when it equals PRESCALE-1.
- On tick, cnt increments modulo 2^PWM_BITS.
- wrap = tick && cnt==all-ones (the last clk cycle of a period).

Targets and levels:
- Target per channel: tgt_x = colour bit ? brightness : 0. Combinational and sampled every cycle; no input registering beyond the level logic.
- Levels change only on wrap. For each channel:
  - If level<tgt: level = min(level+FADE_STEP, tgt).
  - If level>tgt: level = max(level-FADE_STEP, tgt).
  - Else level is held.
- Arithmetic uses PWM_BITS+1 bits; there is no wrap-around or overshoot.
- Channels step independently and simultaneously. A retarget mid-fade (colour or brightness change) takes effect at the next wrap from the current level.

PWM outputs:
- led_x <= enable && (cnt < level_x), one clk latency, registered.
- level 0 gives constant low. Level all-ones gives high for 2^PWM_BITS-1 of 2^PWM_BITS ticks, never constant high.

FSM (state drives busy, registered):
- IDLE -> FADING when any level_x != tgt_x.
- FADING -> IDLE when all level_x == tgt_x, evaluated each cycle.
- busy = (state==FADING). It rises one clk after the mismatch appears and falls one clk after the final wrap update.
- Changing colour to a value whose targets equal the current levels never raises busy.

enable:
- enable=0 forces pins low on the next clk.
- Prescaler, cnt, levels and the fade all continue running.
- Re-enabling resumes at the current phase.

Decomposition:
- Package rgb_pwm_pkg:
  - state enum {IDLE, FADING}
  - channel index constants CH_R=2, CH_G=1, CH_B=0
  - default parameter constants
- Sub-module pwm_fade_channel, instantiated 3 times. It holds the level register, the saturating step toward target on wrap, and the registered comparator output.
- Top contains the prescaler, cnt, FSM and enable gating.

Test Plan:
All tests use bench parameters PWM_BITS=4, PRESCALE=2, FADE_STEP=5, giving a 32-clk period.
1. Reset: rst=1 for 3 clk with colour=3'b111, brightness=15 -> pins 0, busy 0. After release, busy=1 on the first cycle.
2. Fade up from reset: colour=3'b100, brightness=15, enable=1 -> level_r steps 0->5->10->15 at wraps 1,2,3, and busy falls 1 clk after wrap 3. led_r is then high 30 of every 32 clk; led_g and led_b stay 0.
3. Crossfade: at level_r=15, set colour=3'b010 -> at each wrap R goes 15->10->5->0 and G goes 0->5->10->15, concurrently. busy stays high for exactly 3 periods.
4. Saturation: colour=3'b111 with all levels 15; set brightness=7 -> levels go 15->10->7 (not 5), then busy falls. A later brightness change to 8 -> single step 7->8.
5. Enable gating: enable=0 during test 2 -> all pins 0 from the next clk while levels continue to 15. enable=1 -> led_r pattern reappears matching cnt<15 within 1 clk.
6. No-op and mid-fade reset: colour 3'b000->3'b000 with brightness change -> busy never rises. rst=1 mid-fade at level 10 -> levels 0, busy 0, pins 0 next clk.
